ex_muldiv_unit: RTL and testbench

EX_MULDIV_UNIT -- requirements
Module: ex_muldiv_unit

---
 rtl/ex_muldiv_unit_if.sv | 23 ++
 rtl/ex_muldiv_unit.sv | 176 +++++++++++++++++
 tb/tb_ex_muldiv_unit.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ex_muldiv_unit_if.sv
// EX-stage handshake between the pipeline and the iterative M-extension unit.
// The pipeline drives the instruction fields and operands; the unit returns stall/done/result.
interface ex_muldiv_unit_if;
    logic [1:0]  ALUop_in;
    logic [6:0]  funct7_in;
    logic [2:0]  funct3_in;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        flush;
    logic        stall;
    logic        done;
    logic [31:0] result;

    modport master (
        output ALUop_in, funct7_in, funct3_in, op_a, op_b, flush,
        input  stall, done, result
    );

    modport slave (
        input  ALUop_in, funct7_in, funct3_in, op_a, op_b, flush,
        output stall, done, result
    );
endinterface

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring divide,
// fixed 32-step latency, sign correction applied when the result is registered.
module ex_muldiv_unit (
    input  logic            clk,
    input  logic            reset,
    ex_muldiv_unit_if.slave bus
);
    localparam int unsigned XLEN      = 32;
    localparam int unsigned CNT_W     = $clog2(XLEN);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(XLEN - 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [2:0]        op_q, op_d;
    logic [XLEN-1:0]   mcand_q, mcand_d;
    logic [XLEN-1:0]   hi_q, hi_d;
    logic [XLEN-1:0]   lo_q, lo_d;
    logic              neg_res_q, neg_res_d;
    logic              neg_rem_q, neg_rem_d;
    logic              div_zero_q, div_zero_d;
    logic              done_q, done_d;
    logic [XLEN-1:0]   result_q, result_d;

    logic              start;
    logic              a_signed, b_signed, a_neg, b_neg;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_shift;
    logic              div_ge;
    logic [XLEN-1:0]   div_diff;
    logic [XLEN-1:0]   step_hi, step_lo;
    logic [2*XLEN-1:0] prod, prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix, final_res;

    assign start = (bus.ALUop_in == 2'b10) && (bus.funct7_in == 7'b0000001);

    // Operand sign handling: only the signed forms look at bit 31.
    always_comb begin
        a_signed = (bus.funct3_in == 3'b001) || (bus.funct3_in == 3'b010) ||
                   (bus.funct3_in == 3'b100) || (bus.funct3_in == 3'b110);
        b_signed = (bus.funct3_in == 3'b001) || (bus.funct3_in == 3'b100) ||
                   (bus.funct3_in == 3'b110);
        a_neg    = a_signed && bus.op_a[XLEN-1];
        b_neg    = b_signed && bus.op_b[XLEN-1];
        a_mag    = a_neg ? (~bus.op_a + XLEN'(1)) : bus.op_a;
        b_mag    = b_neg ? (~bus.op_b + XLEN'(1)) : bus.op_b;
    end

    // One radix-2 step: {hi,lo} is the product shift register or the remainder/quotient pair.
    always_comb begin
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : (XLEN+1)'(0));
        div_shift = {hi_q, lo_q[XLEN-1]};
        div_ge    = div_shift >= {1'b0, mcand_q};
        div_diff  = div_shift[XLEN-1:0] - mcand_q;
        if (op_q[2]) begin
            step_hi = div_ge ? div_diff : div_shift[XLEN-1:0];
            step_lo = {lo_q[XLEN-2:0], div_ge};
        end else begin
            step_hi = mul_sum[XLEN:1];
            step_lo = {mul_sum[0], lo_q[XLEN-1:1]};
        end
    end

    // Final sign correction and result selection, used on the last CALC step.
    always_comb begin
        prod     = {step_hi, step_lo};
        prod_fix = neg_res_q ? (~prod + (2*XLEN)'(1)) : prod;
        if (div_zero_q)     quo_fix = '1;
        else if (neg_res_q) quo_fix = ~step_lo + XLEN'(1);
        else                quo_fix = step_lo;
        rem_fix  = neg_rem_q ? (~step_hi + XLEN'(1)) : step_hi;
        case (op_q)
            3'b000:                 final_res = prod_fix[XLEN-1:0];
            3'b001, 3'b010, 3'b011: final_res = prod_fix[2*XLEN-1:XLEN];
            3'b100, 3'b101:         final_res = quo_fix;
            default:                final_res = rem_fix;
        endcase
    end

    // Next-state, datapath and output logic.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        op_d       = op_q;
        mcand_d    = mcand_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        neg_res_d  = neg_res_q;
        neg_rem_d  = neg_rem_q;
        div_zero_d = div_zero_q;
        done_d     = 1'b0;
        result_d   = result_q;

        case (state_q)
            IDLE: begin
                if (start && !bus.flush) begin
                    state_d    = CALC;
                    count_d    = '0;
                    op_d       = bus.funct3_in;
                    hi_d       = '0;
                    neg_res_d  = a_neg ^ b_neg;
                    if (bus.funct3_in[2]) begin
                        mcand_d    = b_mag;
                        lo_d       = a_mag;
                        neg_rem_d  = a_neg;
                        div_zero_d = (bus.op_b == '0);
                    end else begin
                        mcand_d    = a_mag;
                        lo_d       = b_mag;
                        neg_rem_d  = 1'b0;
                        div_zero_d = 1'b0;
                    end
                end
            end
            CALC: begin
                hi_d    = step_hi;
                lo_d    = step_lo;
                count_d = count_q + CNT_W'(1);
                if (bus.flush) begin
                    state_d = IDLE;
                end else if (count_q == LAST_STEP) begin
                    state_d  = DONE;
                    done_d   = 1'b1;
                    result_d = final_res;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // stall is combinational so the pipeline freezes in the same cycle start appears.
    always_comb begin
        bus.stall = 1'b0;
        if (!reset) begin
            bus.stall = ((state_q == IDLE) && start && !bus.flush) || (state_q == CALC);
        end
    end

    assign bus.done   = done_q;
    assign bus.result = result_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            count_q    <= '0;
            op_q       <= '0;
            mcand_q    <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            div_zero_q <= 1'b0;
            done_q     <= 1'b0;
            result_q   <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            op_q       <= op_d;
            mcand_q    <= mcand_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            neg_res_q  <= neg_res_d;
            neg_rem_q  <= neg_rem_d;
            div_zero_q <= div_zero_d;
            done_q     <= done_d;
            result_q   <= result_d;
        end
    end
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed bench for ex_muldiv_unit: latency, every funct3 form, divide corner cases,
// flush and reset aborts, and back-to-back issue.
module tb_ex_muldiv_unit;
    logic clk = 1'b0;
    logic reset;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    ex_muldiv_unit_if bus ();

    ex_muldiv_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    localparam vec_t MUL_V [8] = '{
        '{3'b000, 32'h0000_0007, 32'h0000_0006, 32'h0000_002A},
        '{3'b001, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF},
        '{3'b011, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001},
        '{3'b010, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF},
        '{3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001},
        '{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE},
        '{3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000},
        '{3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000}
    };

    localparam vec_t DIV_V [12] = '{
        '{3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD},
        '{3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF},
        '{3'b101, 32'h0000_0064, 32'h0000_0000, 32'hFFFF_FFFF},
        '{3'b111, 32'h0000_0064, 32'h0000_0000, 32'h0000_0064},
        '{3'b100, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFFF},
        '{3'b110, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9},
        '{3'b101, 32'h0000_0064, 32'h0000_0007, 32'h0000_000E},
        '{3'b111, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002},
        '{3'b100, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD},
        '{3'b110, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001},
        '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000},
        '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000}
    };

    task automatic set_idle();
        bus.ALUop_in  = 2'b00;
        bus.funct7_in = 7'd0;
        bus.funct3_in = 3'd0;
        bus.op_a      = 32'd0;
        bus.op_b      = 32'd0;
        bus.flush     = 1'b0;
    endtask

    task automatic set_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        bus.ALUop_in  = 2'b10;
        bus.funct7_in = 7'b0000001;
        bus.funct3_in = f3;
        bus.op_a      = a;
        bus.op_b      = b;
        bus.flush     = 1'b0;
    endtask

    // Holds the instruction in EX until done, like ID/EX with write = ~stall; returns observations.
    task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         output int done_cyc, output int stall_cyc, output logic [31:0] res,
                         output logic done_stall, output time done_t);
        bit seen = 0;
        int cyc  = 0;
        set_op(f3, a, b);
        done_cyc   = 0;
        stall_cyc  = 0;
        res        = 32'd0;
        done_stall = 1'b1;
        done_t     = 0;
        while (!seen && cyc < 60) begin
            #1;
            cyc++;
            if (bus.done === 1'b1) begin
                seen       = 1;
                done_cyc   = cyc;
                res        = bus.result;
                done_stall = bus.stall;
                done_t     = $time;
            end else if (bus.stall === 1'b1) begin
                stall_cyc++;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        int dc, sc;
        logic [31:0] r;
        logic ds;
        time dt;
        reset = 1'b1;
        set_op(3'b000, 32'd7, 32'd6);
        repeat (2) begin
            #2;
            tests++;
            if (bus.stall !== 1'b0) begin fails++; $display("FAIL reset_stall: got %b expected 0", bus.stall); end
            tests++;
            if (bus.done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b expected 0", bus.done); end
            tests++;
            if (bus.result !== 32'h0) begin fails++; $display("FAIL reset_result: got %h expected 00000000", bus.result); end
            @(posedge clk);
        end
        @(negedge clk);
        reset = 1'b0;
        do_op(3'b000, 32'd7, 32'd6, dc, sc, r, ds, dt);
        tests++;
        if (dc !== 34) begin fails++; $display("FAIL first_start_latency: got %0d expected 34", dc); end
        tests++;
        if (r !== 32'h2A) begin fails++; $display("FAIL first_start_result: got %h expected 0000002a", r); end
        set_idle();
        #1;
        tests++;
        if (bus.done !== 1'b0) begin fails++; $display("FAIL done_one_cycle: got %b expected 0", bus.done); end
        tests++;
        if (bus.result !== 32'h2A) begin fails++; $display("FAIL result_hold: got %h expected 0000002a", bus.result); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_vectors(input bit is_div);
        int dc, sc, n;
        logic [31:0] r;
        logic ds;
        time dt;
        vec_t v;
        n = is_div ? 12 : 8;
        for (int i = 0; i < n; i++) begin
            v = is_div ? DIV_V[i] : MUL_V[i % 8];
            do_op(v.f3, v.a, v.b, dc, sc, r, ds, dt);
            set_idle();
            tests++;
            if (r !== v.exp) begin
                fails++;
                $display("FAIL %s[%0d] result: f3=%b a=%h b=%h got %h expected %h",
                         is_div ? "div" : "mul", i, v.f3, v.a, v.b, r, v.exp);
            end
            tests++;
            if (dc !== 34 || sc !== 33 || ds !== 1'b0) begin
                fails++;
                $display("FAIL %s[%0d] timing: done_cycle=%0d stall_cycles=%0d stall_at_done=%b expected 34/33/0",
                         is_div ? "div" : "mul", i, dc, sc, ds);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_flush();
        int dc, sc, seen;
        logic [31:0] r, prev;
        logic ds;
        time dt;
        prev = bus.result;
        set_op(3'b000, 32'd5, 32'd5);
        repeat (11) begin @(posedge clk); #1; end
        tests++;
        if (bus.stall !== 1'b1) begin fails++; $display("FAIL flush_pre_stall: got %b expected 1", bus.stall); end
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        set_idle();
        #1;
        tests++;
        if (bus.stall !== 1'b0) begin fails++; $display("FAIL flush_stall: got %b expected 0", bus.stall); end
        tests++;
        if (bus.result !== prev) begin fails++; $display("FAIL flush_result_hold: got %h expected %h", bus.result, prev); end
        // flush beats start while idle
        set_op(3'b000, 32'd2, 32'd2);
        bus.flush = 1'b1;
        seen = 0;
        repeat (3) begin
            #1;
            if (bus.stall !== 1'b0) seen++;
            @(posedge clk);
            #1;
        end
        tests++;
        if (seen !== 0) begin fails++; $display("FAIL flush_priority: stall seen %0d cycles expected 0", seen); end
        set_idle();
        seen = 0;
        repeat (40) begin
            #1;
            if (bus.done === 1'b1) seen++;
            @(posedge clk);
            #1;
        end
        tests++;
        if (seen !== 0) begin fails++; $display("FAIL flush_no_done: got %0d pulses expected 0", seen); end
        do_op(3'b000, 32'd3, 32'd3, dc, sc, r, ds, dt);
        set_idle();
        tests++;
        if (r !== 32'd9 || dc !== 34) begin fails++; $display("FAIL flush_next_mul: got %h at cycle %0d expected 00000009 at 34", r, dc); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid();
        int seen;
        set_op(3'b000, 32'd9, 32'd9);
        repeat (21) begin @(posedge clk); #1; end
        reset = 1'b1;
        #1;
        tests++;
        if (bus.stall !== 1'b0) begin fails++; $display("FAIL midreset_stall: got %b expected 0", bus.stall); end
        tests++;
        if (bus.done !== 1'b0) begin fails++; $display("FAIL midreset_done: got %b expected 0", bus.done); end
        tests++;
        if (bus.result !== 32'h0) begin fails++; $display("FAIL midreset_result: got %h expected 00000000", bus.result); end
        @(posedge clk);
        #1;
        set_idle();
        reset = 1'b0;
        seen = 0;
        repeat (40) begin
            #1;
            if (bus.done === 1'b1 || bus.stall === 1'b1) seen++;
            @(posedge clk);
            #1;
        end
        tests++;
        if (seen !== 0) begin fails++; $display("FAIL midreset_no_done: activity in %0d cycles expected 0", seen); end
    endtask

    task automatic test_back_to_back();
        int dc1, sc1, dc2, sc2;
        logic [31:0] r1, r2;
        logic ds1, ds2;
        time t1, t2;
        do_op(3'b000, 32'd5, 32'd4, dc1, sc1, r1, ds1, t1);
        do_op(3'b101, 32'd81, 32'd9, dc2, sc2, r2, ds2, t2);
        set_idle();
        tests++;
        if (r1 !== 32'd20) begin fails++; $display("FAIL b2b_mul: got %h expected 00000014", r1); end
        tests++;
        if (r2 !== 32'd9) begin fails++; $display("FAIL b2b_divu: got %h expected 00000009", r2); end
        tests++;
        if (dc1 !== 34 || dc2 !== 34 || (t2 - t1) !== 340) begin
            fails++;
            $display("FAIL b2b_spacing: cycles %0d/%0d gap %0t expected 34/34 gap 340", dc1, dc2, t2 - t1);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        set_idle();
        test_reset();
        test_vectors(1'b0);
        test_vectors(1'b1);
        test_flush();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
